sccb_target: RTL and testbench

SCCB/I2C target (responder) that emulates the camera's register port on the two-wire bus driven by the team's SCCB master. It oversamples SCL/SDA with the system clock, decodes START/STOP, device ID, sub-address and data phases, and presents a simple synchronous register-bank interface. Camera-less board bring-up and closed-loop master verification both use this block.

---
 rtl/sccb_pkg.sv | 29 ++
 rtl/sccb_target_if.sv | 26 ++
 rtl/sccb_line_sync.sv | 51 +++++
 rtl/sccb_target.sv | 211 +++++++++++++++++++++
 tb/tb_sccb_target.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: camera device ID, target FSM states, default
// synchronizer depth and a pointer-advance helper.
package sccb_pkg;

   // 7-bit device ID of the emulated camera; the SCCB master uses the same value.
   localparam logic [6:0] CAM_ADDR = 7'h21;

   // Default depth of the SCL/SDA synchronizer chains (two is the minimum).
   localparam int unsigned SYNC_STAGES_DEF = 2;

   typedef enum logic [3:0] {
      StIdle,
      StId,
      StIdAck,
      StSub,
      StSubAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRdataAck,
      StIgnore
   } sccb_state_e;

   // Register pointer after a completed data byte; wraps 0xFF -> 0x00.
   function automatic logic [7:0] ptr_next(input logic [7:0] ptr, input bit inc);
      return inc ? (ptr + 8'd1) : ptr;
   endfunction

endpackage

// File: rtl/sccb_target_if.sv
// Bus pins and register-bank port of the SCCB target, bundled so the target,
// bench and monitors share one definition. Names follow the target's view.
interface sccb_target_if;

   logic       i_scl;     // SCL as resolved at the pad
   logic       i_sda;     // SDA as resolved at the pad
   logic       o_sda_low; // 1 = pull SDA low, 0 = release
   logic [7:0] o_addr;    // register pointer
   logic [7:0] o_wdata;   // write data
   logic       o_wr_en;   // one-cycle write strobe
   logic [7:0] i_rdata;   // bank contents at o_addr
   logic       o_busy;    // addressed transaction in progress

   // Target side (the responder itself).
   modport slave (
      input  i_scl, i_sda, i_rdata,
      output o_sda_low, o_addr, o_wdata, o_wr_en, o_busy
   );

   // Environment side: pads, register bank, bench.
   modport master (
      output i_scl, i_sda, i_rdata,
      input  o_sda_low, o_addr, o_wdata, o_wr_en, o_busy
   );

endinterface

// File: rtl/sccb_line_sync.sv
// Oversampling front end for a two-wire bus: synchronizes SCL/SDA into the
// system clock domain and flags SCL edges plus START/STOP conditions.
module sccb_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_hist;
   logic                   r_sda_hist;
   logic                   w_scl;
   logic                   w_sda;

   assign w_scl = r_scl_sync[SYNC_STAGES-1];
   assign w_sda = r_sda_sync[SYNC_STAGES-1];

   // Synchronizer chains plus one history stage; the bus idles high.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_hist <= w_scl;
         r_sda_hist <= w_sda;
      end
   end

   // Edge/condition decode; START/STOP need SCL high in both samples.
   always_comb begin
      o_sda      = w_sda;
      o_scl_rise = w_scl & ~r_scl_hist;
      o_scl_fall = ~w_scl & r_scl_hist;
      o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
      o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
   end

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target emulating a camera register port: decodes device ID,
// sub-address and data bytes, ACKs addressed bytes, strobes writes into a
// register bank and shifts bank contents out on reads.
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = CAM_ADDR,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter bit          AUTO_INC    = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   sccb_target_if.slave bus
);

   logic w_sda;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   sccb_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_scl      (bus.i_scl),
      .i_sda      (bus.i_sda),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   sccb_state_e r_state;
   logic [3:0]  r_bit_cnt;  // received bits (rx) or presented bits (tx), 0..8
   logic [6:0]  r_rx;       // bits received so far in the current byte
   logic [6:0]  r_tx;       // read bits still to be presented, next one at [6]
   logic        r_rw;       // R/W bit of the last matching ID byte
   logic        r_ack_drv;  // ACK slot: 1 once SDA has been pulled for this slot
   logic        r_inc_pend; // pointer advance due in the cycle after a write strobe
   logic        r_sda_low;
   logic [7:0]  r_addr;
   logic [7:0]  r_wdata;
   logic        r_wr_en;
   logic        r_busy;
   logic [7:0]  w_byte_nxt;

   // Byte as it stands once the bit sampled on this scl_rise is shifted in.
   assign w_byte_nxt = {r_rx, w_sda};

   assign bus.o_sda_low = r_sda_low;
   assign bus.o_addr    = r_addr;
   assign bus.o_wdata   = r_wdata;
   assign bus.o_wr_en   = r_wr_en;
   assign bus.o_busy    = r_busy;

   // Protocol FSM with registered bus/bank outputs; START/STOP override any state.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state    <= StIdle;
         r_bit_cnt  <= 4'd0;
         r_rx       <= 7'd0;
         r_tx       <= 7'd0;
         r_rw       <= 1'b0;
         r_ack_drv  <= 1'b0;
         r_inc_pend <= 1'b0;
         r_sda_low  <= 1'b0;
         r_addr     <= 8'h00;
         r_wdata    <= 8'h00;
         r_wr_en    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_wr_en    <= 1'b0;
         r_inc_pend <= 1'b0;
         if (r_inc_pend) begin
            r_addr <= ptr_next(r_addr, 1'b1);
         end

         if (w_start) begin
            // Repeated START behaves exactly like a fresh one; a partial byte is dropped.
            r_state   <= StId;
            r_bit_cnt <= 4'd0;
            r_rx      <= 7'd0;
            r_sda_low <= 1'b0;
            r_ack_drv <= 1'b0;
         end else if (w_stop) begin
            r_state   <= StIdle;
            r_sda_low <= 1'b0;
            r_ack_drv <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle, StIgnore: begin
                  // Wait for START; SDA is never driven here.
               end

               StId: begin
                  if (w_scl_rise) begin
                     r_rx <= w_byte_nxt[6:0];
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= 4'd0;
                        if (w_byte_nxt[7:1] == DEV_ADDR) begin
                           r_rw    <= w_byte_nxt[0];
                           r_busy  <= 1'b1;
                           r_state <= StIdAck;
                        end else begin
                           r_busy  <= 1'b0;
                           r_state <= StIgnore;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end

               StSub: begin
                  if (w_scl_rise) begin
                     r_rx <= w_byte_nxt[6:0];
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= 4'd0;
                        r_addr    <= w_byte_nxt;
                        r_state   <= StSubAck;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end

               StWdata: begin
                  if (w_scl_rise) begin
                     r_rx <= w_byte_nxt[6:0];
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt  <= 4'd0;
                        r_wdata    <= w_byte_nxt;
                        r_wr_en    <= 1'b1;
                        r_inc_pend <= AUTO_INC;
                        r_state    <= StWdataAck;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end

               StIdAck, StSubAck, StWdataAck: begin
                  // First fall after the 8th bit pulls SDA; the next one ends the slot.
                  if (w_scl_fall) begin
                     if (!r_ack_drv) begin
                        r_sda_low <= 1'b1;
                        r_ack_drv <= 1'b1;
                     end else begin
                        r_ack_drv <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_rx      <= 7'd0;
                        if ((r_state == StIdAck) && r_rw) begin
                           // Read: first data bit goes out on the fall ending the ACK.
                           r_tx      <= bus.i_rdata[6:0];
                           r_sda_low <= ~bus.i_rdata[7];
                           r_bit_cnt <= 4'd1;
                           r_state   <= StRdata;
                        end else begin
                           r_sda_low <= 1'b0;
                           r_state   <= (r_state == StIdAck) ? StSub : StWdata;
                        end
                     end
                  end
               end

               StRdata: begin
                  if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd0) begin
                        // Follow-on byte after a master ACK; pointer has already moved.
                        r_tx      <= bus.i_rdata[6:0];
                        r_sda_low <= ~bus.i_rdata[7];
                        r_bit_cnt <= 4'd1;
                     end else if (r_bit_cnt < 4'd8) begin
                        r_sda_low <= ~r_tx[6];
                        r_tx      <= {r_tx[5:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end else begin
                        r_sda_low <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= StRdataAck;
                     end
                  end
               end

               StRdataAck: begin
                  if (w_scl_rise) begin
                     if (!w_sda) begin
                        r_addr    <= ptr_next(r_addr, AUTO_INC);
                        r_bit_cnt <= 4'd0;
                        r_state   <= StRdata;
                     end else begin
                        // Master NACK ends the read; stay silent until START/STOP.
                        r_state <= StIgnore;
                     end
                  end
               end

               default: begin
                  r_state   <= StIdle;
                  r_sda_low <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a bit-banged SCCB master on an open-drain
// bus, a register bank, and a transaction-level model of the target.
module tb_sccb_target;
   import sccb_pkg::*;

   localparam int unsigned H        = 16;    // i_clk cycles per SCL half period
   localparam logic [6:0]  DEV      = 7'h21;
   localparam bit          AUTO_INC = 1'b1;

   typedef enum {PhNone, PhId, PhSub, PhWr, PhRd} ph_e;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   logic may_drive = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sccb_target_if bus_if ();

   assign bus_if.i_scl = m_scl;
   assign bus_if.i_sda = m_sda & ~bus_if.o_sda_low;

   sccb_target #(
      .DEV_ADDR    (DEV),
      .SYNC_STAGES (2),
      .AUTO_INC    (AUTO_INC)
   ) u_dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus_if)
   );

   // Register bank: preset contents while in reset, written by the strobe.
   logic [7:0] bank [256];
   assign bus_if.i_rdata = bank[bus_if.o_addr];

   function automatic logic [7:0] preset(input int i);
      logic [7:0] v;
      v = i[7:0];
      return (v == 8'h0A) ? 8'h76 : (v ^ 8'h5A);
   endfunction

   always @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < 256; i++) bank[i] <= preset(i);
      end else if (bus_if.o_wr_en) begin
         bank[bus_if.o_addr] <= bus_if.o_wdata;
      end
   end

   // Transaction-level model of what the target must do.
   ph_e         m_phase;
   logic [7:0]  m_addr;
   logic        m_busy;
   logic [7:0]  exp_mem [256];
   logic [15:0] exp_wr_q [$];
   logic [15:0] wr_exp;

   task automatic model_reset();
      m_phase = PhNone;
      m_addr  = 8'h00;
      m_busy  = 1'b0;
      exp_wr_q.delete();
      for (int i = 0; i < 256; i++) exp_mem[i] = preset(i);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Every cycle: no SDA pull outside allowed windows, and each strobe matches the model.
   always @(negedge clk) begin
      if (rstn) begin
         n_tests++;
         if (bus_if.o_sda_low && !may_drive) begin
            n_fail++;
            $display("FAIL sda_drive: got o_sda_low=1, want 0 at %0t", $time);
         end
         if (bus_if.o_wr_en) begin
            n_tests++;
            if (exp_wr_q.size() == 0) begin
               n_fail++;
               $display("FAIL strobe: got write 0x%0h=0x%0h, want none",
                        bus_if.o_addr, bus_if.o_wdata);
            end else begin
               wr_exp = exp_wr_q.pop_front();
               if ({bus_if.o_addr, bus_if.o_wdata} !== wr_exp) begin
                  n_fail++;
                  $display("FAIL strobe: got 0x%0h=0x%0h, want 0x%0h=0x%0h",
                           bus_if.o_addr, bus_if.o_wdata, wr_exp[15:8], wr_exp[7:0]);
               end
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   // One SCL clock: set SDA mid-low, sample resolved SDA mid-high, end with SCL falling.
   task automatic clock_bit(input logic b, output logic s);
      wait_clk(H / 2);
      m_sda = b;
      wait_clk(H / 2);
      m_scl = 1'b1;
      wait_clk(H / 2);
      @(negedge clk);
      s = bus_if.i_sda;
      wait_clk(H / 2);
      m_scl = 1'b0;
   endtask

   task automatic tx_start();
      m_sda = 1'b1;
      wait_clk(H);
      m_scl = 1'b1;
      wait_clk(H);
      m_sda = 1'b0;
      wait_clk(H);
      m_scl = 1'b0;
      m_phase = PhId;
   endtask

   task automatic tx_stop();
      wait_clk(H / 2);
      m_sda = 1'b0;
      wait_clk(H / 2);
      m_scl = 1'b1;
      wait_clk(H);
      m_sda = 1'b1;
      wait_clk(H);
      m_phase = PhNone;
      m_busy  = 1'b0;
      @(negedge clk);
      chk("stop_busy", {31'd0, bus_if.o_busy}, {31'd0, m_busy});
      chk("stop_addr", {24'd0, bus_if.o_addr}, {24'd0, m_addr});
   endtask

   task automatic tx_byte(input logic [7:0] b);
      logic exp_ack;
      logic ack;
      logic s;
      case (m_phase)
         PhId: begin
            exp_ack = (b[7:1] != DEV);
            m_busy  = !exp_ack;
            m_phase = exp_ack ? PhNone : (b[0] ? PhRd : PhSub);
         end
         PhSub: begin
            exp_ack = 1'b0;
            m_addr  = b;
            m_phase = PhWr;
         end
         PhWr: begin
            exp_ack = 1'b0;
            exp_wr_q.push_back({m_addr, b});
            exp_mem[m_addr] = b;
            if (AUTO_INC) m_addr = m_addr + 8'd1;
         end
         default: exp_ack = 1'b1;
      endcase
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      may_drive = !exp_ack;
      clock_bit(1'b1, ack);
      wait_clk(8);
      may_drive = (m_phase == PhRd);
      @(negedge clk);
      chk($sformatf("ack_%02h", b), {31'd0, ack}, {31'd0, exp_ack});
      chk($sformatf("addr_after_%02h", b), {24'd0, bus_if.o_addr}, {24'd0, m_addr});
      chk($sformatf("busy_after_%02h", b), {31'd0, bus_if.o_busy}, {31'd0, m_busy});
   endtask

   task automatic tx_read(input logic mack, output logic [7:0] d);
      logic [7:0] exp_d;
      logic s;
      exp_d = exp_mem[m_addr];
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(mack, s);
      if (!mack) begin
         if (AUTO_INC) m_addr = m_addr + 8'd1;
      end else begin
         m_phase = PhNone;
      end
      wait_clk(8);
      may_drive = (m_phase == PhRd);
      @(negedge clk);
      chk("read_data", {24'd0, d}, {24'd0, exp_d});
      chk("read_addr", {24'd0, bus_if.o_addr}, {24'd0, m_addr});
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       s;
      model_reset();
      wait_clk(5);
      @(negedge clk);
      chk("rst_sda_low", {31'd0, bus_if.o_sda_low}, 32'd0);
      chk("rst_addr",    {24'd0, bus_if.o_addr},    32'h00);
      chk("rst_wdata",   {24'd0, bus_if.o_wdata},   32'h00);
      chk("rst_wr_en",   {31'd0, bus_if.o_wr_en},   32'd0);
      chk("rst_busy",    {31'd0, bus_if.o_busy},    32'd0);
      rstn = 1'b1;
      wait_clk(10);

      // Write 0x12 = 0x80.
      tx_start();
      tx_byte(8'h42);
      tx_byte(8'h12);
      tx_byte(8'h80);
      tx_stop();
      chk("w12_addr",  {24'd0, bus_if.o_addr},  32'h13);
      chk("w12_wdata", {24'd0, bus_if.o_wdata}, 32'h80);

      // Read 0x0A via write-ID + sub-address, STOP, read-ID, master NACK.
      tx_start();
      tx_byte(8'h42);
      tx_byte(8'h0A);
      tx_stop();
      tx_start();
      tx_byte(8'h43);
      tx_read(1'b1, d);
      chk("r0a_data", {24'd0, d}, 32'h76);
      wait_clk(2 * H);
      tx_stop();
      chk("r0a_addr", {24'd0, bus_if.o_addr}, 32'h0A);

      // Wrong device ID: no ACK, never busy, following byte ignored.
      tx_start();
      tx_byte(8'h44);
      chk("badid_busy", {31'd0, bus_if.o_busy}, 32'd0);
      tx_byte(8'h55);
      tx_stop();

      // Repeated START after sub-address 0xFF, two-byte read across the wrap.
      tx_start();
      tx_byte(8'h42);
      tx_byte(8'hFF);
      tx_start();
      tx_byte(8'h43);
      tx_read(1'b0, d);
      chk("wrap_rd0", {24'd0, d}, 32'hA5);
      tx_read(1'b1, d);
      chk("wrap_rd1", {24'd0, d}, 32'h5A);
      tx_stop();
      chk("wrap_addr", {24'd0, bus_if.o_addr}, 32'h00);

      // STOP after four data bits aborts the byte.
      tx_start();
      tx_byte(8'h42);
      tx_byte(8'h30);
      for (int i = 7; i >= 4; i--) clock_bit(1'b1 ^ i[0], s);
      tx_stop();
      chk("abort_addr", {24'd0, bus_if.o_addr}, 32'h30);
      chk("abort_busy", {31'd0, bus_if.o_busy}, 32'd0);

      // Burst write across the pointer wrap.
      tx_start();
      tx_byte(8'h42);
      tx_byte(8'hFE);
      tx_byte(8'h11);
      tx_byte(8'h22);
      tx_byte(8'h33);
      tx_stop();
      chk("burst_addr", {24'd0, bus_if.o_addr}, 32'h01);

      // Reset asserted while the target holds the ID ACK.
      tx_start();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] idb;
         idb = 8'h42;
         clock_bit(idb[i], s);
      end
      may_drive = 1'b1;
      wait_clk(6);
      @(negedge clk);
      chk("ack_driven", {31'd0, bus_if.o_sda_low}, 32'd1);
      #3 rstn = 1'b0;
      #1;
      chk("arst_sda_low", {31'd0, bus_if.o_sda_low}, 32'd0);
      chk("arst_addr",    {24'd0, bus_if.o_addr},    32'h00);
      chk("arst_wdata",   {24'd0, bus_if.o_wdata},   32'h00);
      chk("arst_wr_en",   {31'd0, bus_if.o_wr_en},   32'd0);
      chk("arst_busy",    {31'd0, bus_if.o_busy},    32'd0);
      model_reset();
      may_drive = 1'b0;
      wait_clk(4);
      @(negedge clk);
      rstn = 1'b1;
      tx_stop();

      // Normal decode after reset.
      tx_start();
      tx_byte(8'h42);
      tx_byte(8'h05);
      tx_byte(8'h99);
      tx_stop();
      chk("post_rst_addr",  {24'd0, bus_if.o_addr},  32'h06);
      chk("post_rst_wdata", {24'd0, bus_if.o_wdata}, 32'h99);

      wait_clk(20);
      chk("pending_writes", exp_wr_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
